// File: rtl/sia_wbm_poller_if.sv
`default_nettype none
// ============================================================================
// Module      : sia_wbm_poller_if
// Description : Wishbone B.4 pipelined bus between the SIA polling master and
//               the sia_wb slave. Signal names keep the master's direction
//               suffixes so that both ends read the same way.
//               adr_o[2:0] word address, we_o, cyc_o, stb_o, sel_o[1:0],
//               dat_o[15:0] (master -> slave); dat_i[15:0], ack_i, stall_i
//               (slave -> master).
// Revision    : 1.0 - initial release
// ============================================================================
interface sia_wbm_poller_if;
    logic [2:0]  adr_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [1:0]  sel_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        ack_i;
    logic        stall_i;

    modport master (
        output adr_o, we_o, cyc_o, stb_o, sel_o, dat_o,
        input  dat_i, ack_i, stall_i
    );

    modport slave (
        input  adr_o, we_o, cyc_o, stb_o, sel_o, dat_o,
        output dat_i, ack_i, stall_i
    );
endinterface
`default_nettype wire

// File: rtl/sia_wbm_poller.sv
`default_nettype none
// ============================================================================
// Module      : sia_wbm_poller
// Description : Wishbone pipelined master that polls one sia_wb slave. It
//               reads STATUS, pops received words from TRXDAT into a one-word
//               holding register, and writes stream words into TRXDAT when the
//               transmit queue has room. One bus transaction in flight.
// Ports       : clk_i, reset_i (async, active high), enable_i
//               wb          - Wishbone master modport
//               rx_dat_o / rx_valid_o / rx_ready_i - receive stream out
//               tx_dat_i / tx_valid_i / tx_ready_o - transmit stream in
//               err_o       - one-cycle pulse on ack timeout
// Revision    : 1.0 - initial release
// ============================================================================
module sia_wbm_poller #(
    parameter int         RXNE_BIT    = 0,
    parameter int         TXNF_BIT    = 1,
    parameter int         POLL_GAP    = 15,
    parameter int         ACK_TIMEOUT = 255,
    parameter logic [2:0] ADR_STATUS  = 3'd0,
    parameter logic [2:0] ADR_TRXDAT  = 3'd1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    sia_wbm_poller_if.master wb,
    output logic [15:0]      rx_dat_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    input  logic [15:0]      tx_dat_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             err_o
);

    localparam int c_GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam int c_TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_RELOAD = c_GAP_W'(POLL_GAP);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POLL = 2'd1,
        S_RXRD = 2'd2,
        S_TXWR = 2'd3
    } state_t;

    state_t               r_state,    w_state;
    logic                 r_cyc,      w_cyc;
    logic                 r_stb,      w_stb;
    logic                 r_we,       w_we;
    logic [1:0]           r_sel,      w_sel;
    logic [2:0]           r_adr,      w_adr;
    logic [15:0]          r_dat,      w_dat;
    logic [c_GAP_W-1:0]   r_gap,      w_gap;
    logic [c_TMO_W-1:0]   r_tmo,      w_tmo;
    logic                 r_last_tx,  w_last_tx;   // side served last (1 = TX)
    logic [15:0]          r_rx_dat,   w_rx_dat;
    logic                 r_rx_valid, w_rx_valid;
    logic                 r_tx_ready, w_tx_ready;
    logic                 r_err,      w_err;
    logic                 w_rx_work;
    logic                 w_tx_work;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 2'b00;
            r_adr      <= 3'd0;
            r_dat      <= 16'h0000;
            r_gap      <= '0;
            r_tmo      <= '0;
            r_last_tx  <= 1'b1;    // first contested choice goes to RX
            r_rx_dat   <= 16'h0000;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cyc      <= w_cyc;
            r_stb      <= w_stb;
            r_we       <= w_we;
            r_sel      <= w_sel;
            r_adr      <= w_adr;
            r_dat      <= w_dat;
            r_gap      <= w_gap;
            r_tmo      <= w_tmo;
            r_last_tx  <= w_last_tx;
            r_rx_dat   <= w_rx_dat;
            r_rx_valid <= w_rx_valid;
            r_tx_ready <= w_tx_ready;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cyc      = r_cyc;
        w_stb      = r_stb;
        w_we       = r_we;
        w_sel      = r_sel;
        w_adr      = r_adr;
        w_dat      = r_dat;
        w_gap      = r_gap;
        w_tmo      = r_tmo;
        w_last_tx  = r_last_tx;
        w_rx_dat   = r_rx_dat;
        w_rx_valid = r_rx_valid;
        w_tx_ready = 1'b0;
        w_err      = 1'b0;

        // Work decision uses the holding register as it is now; a word being
        // consumed this very cycle only delays the next read by one poll.
        w_rx_work = wb.dat_i[RXNE_BIT] & ~r_rx_valid;
        w_tx_work = wb.dat_i[TXNF_BIT] & tx_valid_i;

        if (r_rx_valid && rx_ready_i) begin
            w_rx_valid = 1'b0;
        end

        // Common bus progress: strobe drops on acceptance, the cycle ends on
        // ack (possibly in the acceptance cycle) or on the ack timeout.
        if (r_cyc) begin
            if (r_stb && !wb.stall_i) begin
                w_stb = 1'b0;
                w_tmo = '0;
            end else if (!r_stb) begin
                w_tmo = r_tmo + c_TMO_W'(1);
            end
            if (wb.ack_i || (!r_stb && r_tmo == c_TMO_LAST)) begin
                w_cyc = 1'b0;
                w_stb = 1'b0;
                w_we  = 1'b0;
                w_sel = 2'b00;
                w_adr = 3'd0;
                w_dat = 16'h0000;
            end
            if (!wb.ack_i && !r_stb && r_tmo == c_TMO_LAST) begin
                w_err   = 1'b1;
                w_gap   = c_GAP_RELOAD;
                w_state = S_IDLE;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (enable_i && r_gap == '0) begin
                    w_state = S_POLL;
                    w_cyc   = 1'b1;
                    w_stb   = 1'b1;
                    w_sel   = 2'b11;
                    w_adr   = ADR_STATUS;
                    w_we    = 1'b0;
                    w_dat   = 16'h0000;
                end else if (r_gap != '0) begin
                    w_gap = r_gap - c_GAP_W'(1);
                end
            end
            S_POLL: begin
                if (r_cyc && wb.ack_i) begin
                    if (w_rx_work && (!w_tx_work || r_last_tx)) begin
                        w_state = S_RXRD;
                    end else if (w_tx_work) begin
                        w_state = S_TXWR;
                    end else begin
                        w_state = S_IDLE;
                        w_gap   = c_GAP_RELOAD;
                    end
                end
            end
            S_RXRD: begin
                if (!r_cyc) begin
                    w_cyc = 1'b1;
                    w_stb = 1'b1;
                    w_sel = 2'b11;
                    w_adr = ADR_TRXDAT;
                    w_we  = 1'b0;
                    w_dat = 16'h0000;
                end else if (wb.ack_i) begin
                    w_rx_dat   = wb.dat_i;
                    w_rx_valid = 1'b1;
                    w_last_tx  = 1'b0;
                    w_state    = S_IDLE;
                    w_gap      = '0;
                end
            end
            S_TXWR: begin
                if (!r_cyc) begin
                    w_cyc = 1'b1;
                    w_stb = 1'b1;
                    w_sel = 2'b11;
                    w_adr = ADR_TRXDAT;
                    w_we  = 1'b1;
                    w_dat = tx_dat_i;
                end else if (wb.ack_i) begin
                    w_tx_ready = 1'b1;
                    w_last_tx  = 1'b1;
                    w_state    = S_IDLE;
                    w_gap      = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign wb.cyc_o   = r_cyc;
    assign wb.stb_o   = r_stb;
    assign wb.we_o    = r_we;
    assign wb.sel_o   = r_sel;
    assign wb.adr_o   = r_adr;
    assign wb.dat_o   = r_dat;
    assign rx_dat_o   = r_rx_dat;
    assign rx_valid_o = r_rx_valid;
    assign tx_ready_o = r_tx_ready;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sia_wbm_poller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sia_wbm_poller
// Description : Self-checking bench for sia_wbm_poller with a pipelined
//               Wishbone slave model, an RX consumer and a TX producer.
//               RX words are queued when the slave returns them and compared
//               when the consumer takes them; TX words are queued when offered
//               and compared when the slave sees the write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sia_wbm_poller;

    localparam int          POLL_GAP    = 3;
    localparam int          ACK_TIMEOUT = 8;
    localparam logic [2:0]  ADR_STATUS  = 3'd0;
    localparam logic [2:0]  ADR_TRXDAT  = 3'd1;
    localparam logic [15:0] ST_RXNE     = 16'h0001;
    localparam logic [15:0] ST_TXNF     = 16'h0002;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] rx_dat;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] tx_dat;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    sia_wbm_poller_if bus ();

    sia_wbm_poller #(
        .RXNE_BIT    (0),
        .TXNF_BIT    (1),
        .POLL_GAP    (POLL_GAP),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .ADR_STATUS  (ADR_STATUS),
        .ADR_TRXDAT  (ADR_TRXDAT)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .wb         (bus),
        .rx_dat_o   (rx_dat),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .tx_dat_i   (tx_dat),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .err_o      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];

    // Slave model state
    logic [15:0] status_val  = 16'h0000;
    logic [15:0] rx_next     = 16'h0000;
    int          stall_cfg   = 0;
    int          stall_left  = 0;
    logic        suppress    = 1'b0;
    logic        in_req      = 1'b0;
    logic        got_req     = 1'b0;
    logic [2:0]  req_adr     = 3'd0;
    logic        req_we      = 1'b0;
    logic [15:0] req_dat     = 16'h0000;
    int          n_status    = 0;
    int          n_rd        = 0;
    int          n_wr        = 0;
    int          cyc_cnt     = 0;
    int          wr_ack_cyc  = 0;
    int          prev_kind   = 0;
    logic        alt_check   = 1'b0;

    // Producer / monitors
    logic        tx_auto     = 1'b0;
    logic [15:0] tx_word     = 16'h0000;
    int          n_txr       = 0;
    int          n_err       = 0;
    logic        prev_txr    = 1'b0;
    logic        prev_err    = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Pipelined slave: decides stall/ack on the falling edge for the next
    // rising edge; ack comes the cycle after acceptance.
    initial begin
        bus.ack_i   = 1'b0;
        bus.stall_i = 1'b0;
        bus.dat_i   = 16'hDEAD;
        forever begin
            @(negedge clk);
            bus.ack_i   = 1'b0;
            bus.stall_i = 1'b0;
            bus.dat_i   = 16'hDEAD;
            if (reset) begin
                in_req  = 1'b0;
                got_req = 1'b0;
            end else if (!bus.cyc_o) begin
                check("idle_bus", {10'd0, bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o}, 32'd0);
                in_req  = 1'b0;
                got_req = 1'b0;
            end else if (bus.stb_o) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    stall_left = stall_cfg;
                    stall_cfg  = 0;
                end
                if (stall_left > 0) begin
                    bus.stall_i = 1'b1;
                    stall_left--;
                end else begin
                    check("acc_sel", {30'd0, bus.sel_o}, 32'd3);
                    req_adr = bus.adr_o;
                    req_we  = bus.we_o;
                    req_dat = bus.dat_o;
                    in_req  = 1'b0;
                    got_req = 1'b1;
                end
            end else if (got_req && !suppress) begin
                bus.ack_i = 1'b1;
                got_req   = 1'b0;
                if (req_adr == ADR_STATUS && !req_we) begin
                    bus.dat_i = status_val;
                    n_status++;
                end else begin
                    check("trx_adr", {29'd0, req_adr}, {29'd0, ADR_TRXDAT});
                    if (!req_we) begin
                        bus.dat_i = rx_next;
                        rx_q.push_back(rx_next);
                        rx_next = rx_next + 16'h0001;
                        n_rd++;
                        if (alt_check && prev_kind != 0) check("rr_alt", 1, 3 - prev_kind);
                        prev_kind = 1;
                    end else begin
                        if (tx_q.size() == 0) check("wr_unexpected", tx_q.size(), 1);
                        else check("wr_dat", {16'd0, req_dat}, {16'd0, tx_q.pop_front()});
                        wr_ack_cyc = cyc_cnt;
                        n_wr++;
                        if (alt_check && prev_kind != 0) check("rr_alt", 2, 3 - prev_kind);
                        prev_kind = 2;
                    end
                end
            end
        end
    end

    // RX consumer
    initial forever begin
        @(negedge clk);
        if (!reset && rx_valid && rx_ready) begin
            if (rx_q.size() == 0) check("rx_unexpected", rx_q.size(), 1);
            else check("rx_dat", {16'd0, rx_dat}, {16'd0, rx_q.pop_front()});
        end
    end

    // TX producer and pulse monitors
    initial forever begin
        @(negedge clk);
        if (tx_ready) begin
            check("txr_latency", cyc_cnt, wr_ack_cyc + 1);
            check("txr_width", {31'd0, prev_txr}, 32'd0);
            n_txr++;
            if (tx_auto) begin
                tx_word = tx_word + 16'h0001;
                tx_dat  = tx_word;
                tx_q.push_back(tx_word);
            end else begin
                tx_valid = 1'b0;
            end
        end
        if (err) begin
            check("err_width", {31'd0, prev_err}, 32'd0);
            n_err++;
        end
        prev_txr = tx_ready;
        prev_err = err;
    end

    task automatic wait_cyc(input logic v, input string tag);
        int i = 0;
        while (bus.cyc_o !== v && i < 300) begin
            @(negedge clk);
            i++;
        end
        check(tag, {31'd0, bus.cyc_o}, {31'd0, v});
    endtask

    int i;
    int gap;
    int base;
    int base2;
    int n_stb;
    int n_wait;
    logic [2:0] adr0;

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_dat   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_bus", {10'd0, bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o}, 32'd0);
        check("rst_rx", {15'd0, rx_valid, rx_dat}, 32'd0);
        check("rst_pulses", {30'd0, tx_ready, err}, 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        enable = 1'b1;

        // 1: idle polling, STATUS only, spaced by the poll gap
        base  = n_status;
        base2 = n_rd + n_wr;
        for (int p = 0; p < 3; p++) begin
            wait_cyc(1'b1, "t1_cyc_rise");
            check("t1_adr", {29'd0, bus.adr_o}, {29'd0, ADR_STATUS});
            check("t1_we", {31'd0, bus.we_o}, 32'd0);
            wait_cyc(1'b0, "t1_cyc_fall");
            gap = 0;
            while (!bus.cyc_o && gap < 100) begin
                gap++;
                @(negedge clk);
            end
            check("t1_gap", {31'd0, gap >= POLL_GAP}, 32'd1);
        end
        check("t1_polls", {31'd0, n_status >= base + 3}, 32'd1);
        check("t1_no_trx", n_rd + n_wr, base2);

        // 2: receive one word, then hold it while RXNE stays set
        @(posedge clk); #1;
        rx_next    = 16'hABCD;
        status_val = ST_RXNE;
        i = 0;
        while (!rx_valid && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("t2_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("t2_rx_dat", {16'd0, rx_dat}, 32'h0000ABCD);
        base  = n_status;
        base2 = n_rd;
        i = 0;
        while (n_status < base + 3 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("t2_repolled", {31'd0, n_status >= base + 3}, 32'd1);
        check("t2_no_reread", n_rd, base2);
        check("t2_held", {15'd0, rx_valid, rx_dat}, 32'h0001ABCD);
        @(posedge clk); #1;
        status_val = 16'h0000;
        rx_ready   = 1'b1;
        i = 0;
        while (rx_q.size() != 0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("t2_drained", rx_q.size(), 0);

        // 3: single write of 16'hBEEF
        @(posedge clk); #1;
        tx_dat = 16'hBEEF;
        tx_q.push_back(16'hBEEF);
        tx_valid   = 1'b1;
        status_val = ST_TXNF;
        base = n_txr;
        i = 0;
        while (n_txr == base && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("t3_tx_ready", n_txr, base + 1);
        base  = n_status;
        base2 = n_wr;
        i = 0;
        while (n_status < base + 2 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("t3_no_rewrite", n_wr, base2);
        check("t3_tx_q", tx_q.size(), 0);

        // 4: both sides busy -> alternate, then disable
        @(posedge clk); #1;
        tx_word = 16'h1000;
        tx_dat  = tx_word;
        tx_q.push_back(tx_word);
        tx_auto    = 1'b1;
        tx_valid   = 1'b1;
        rx_next    = 16'h5A00;
        prev_kind  = 0;
        alt_check  = 1'b1;
        status_val = ST_RXNE | ST_TXNF;
        base = n_rd + n_wr;
        i = 0;
        while (n_rd + n_wr < base + 6 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("t4_services", {31'd0, n_rd + n_wr >= base + 6}, 32'd1);
        @(posedge clk); #1;
        alt_check = 1'b0;
        enable    = 1'b0;
        repeat (20) @(negedge clk);
        base = n_status + n_rd + n_wr;
        repeat (30) @(negedge clk);
        check("t4_quiet", n_status + n_rd + n_wr, base);
        check("t4_rx_drained", rx_q.size(), 0);
        @(posedge clk); #1;
        tx_auto    = 1'b0;
        tx_valid   = 1'b0;
        tx_q.delete();
        status_val = 16'h0000;

        // 5: stall a STATUS poll for 3 cycles, then withhold ack
        stall_cfg = 3;
        suppress  = 1'b1;
        enable    = 1'b1;
        i = 0;
        while (!bus.stb_o && i < 100) begin
            @(negedge clk);
            i++;
        end
        adr0  = bus.adr_o;
        check("t5_adr", {29'd0, adr0}, {29'd0, ADR_STATUS});
        n_stb = 0;
        while (bus.stb_o && n_stb < 20) begin
            n_stb++;
            check("t5_adr_stable", {29'd0, bus.adr_o}, {29'd0, adr0});
            @(negedge clk);
        end
        check("t5_stb_cycles", n_stb, 4);
        n_wait = 0;
        while (bus.cyc_o && n_wait < ACK_TIMEOUT + 20) begin
            n_wait++;
            @(negedge clk);
        end
        check("t5_timeout_cycles", n_wait, ACK_TIMEOUT);
        check("t5_err", {31'd0, err}, 32'd1);
        suppress = 1'b0;
        gap = 0;
        while (!bus.cyc_o && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        check("t5_gap_reload", {31'd0, gap >= POLL_GAP}, 32'd1);

        // 6: reset in the middle of a write cycle
        @(posedge clk); #1;
        tx_dat = 16'h1234;
        tx_q.push_back(16'h1234);
        tx_valid   = 1'b1;
        status_val = ST_TXNF;
        i = 0;
        while (!(bus.cyc_o && bus.stb_o && bus.we_o) && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("t6_in_write", {31'd0, bus.we_o}, 32'd1);
        base = n_txr;
        #1 reset = 1'b1;
        #1;
        check("t6_async_drop", {30'd0, bus.cyc_o, bus.stb_o}, 32'd0);
        tx_valid   = 1'b0;
        status_val = 16'h0000;
        repeat (3) @(negedge clk);
        check("t6_rst_bus", {10'd0, bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o}, 32'd0);
        check("t6_rst_rx", {15'd0, rx_valid, rx_dat}, 32'd0);
        @(posedge clk); #1;
        tx_q.delete();
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_tx_ready", n_txr, base);
        check("err_total", n_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
